// File: rtl/pwm_sched_pkg.sv
// Shared constants, state encoding and command-field helpers for the PWM command scheduler.
package pwm_sched_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned DUTY_MSB = 15;
  localparam int unsigned DUTY_LSB = 8;
  localparam int unsigned PER_MSB  = 7;
  localparam int unsigned PER_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    CHECK,
    COMMIT
  } sched_state_e;

  function automatic logic [FIELD_W-1:0] cmd_duty(input logic [DATA_W-1:0] cmd);
    return cmd[DUTY_MSB:DUTY_LSB];
  endfunction

  function automatic logic [FIELD_W-1:0] cmd_period(input logic [DATA_W-1:0] cmd);
    return cmd[PER_MSB:PER_LSB];
  endfunction

  // A command is usable when the period is non-zero and duty fits inside it.
  function automatic logic cmd_valid(input logic [DATA_W-1:0] cmd);
    return (cmd_period(cmd) != '0) && (cmd_duty(cmd) <= cmd_period(cmd));
  endfunction

endpackage

// File: rtl/pwm_shadow_reg.sv
// Per-channel shadow/active configuration pair; shadow moves to active only at a period boundary.
module pwm_shadow_reg
  import pwm_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               period_end,
  output logic [FIELD_W-1:0] duty,
  output logic [FIELD_W-1:0] period,
  output logic               pending,
  output logic               enable
);

  logic [DATA_W-1:0] shadow;

  // Apply takes priority; a write is only accepted while nothing is pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow  <= '0;
      pending <= 1'b0;
      duty    <= '0;
      period  <= '0;
      enable  <= 1'b0;
    end else if (period_end && pending) begin
      duty    <= cmd_duty(shadow);
      period  <= cmd_period(shadow);
      pending <= 1'b0;
      enable  <= 1'b1;
    end else if (wr_en && !pending) begin
      shadow  <= wr_data;
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_cmd_scheduler.sv
// Pops command words from the FIFO, validates them and hands them round-robin to PWM channels.
module pwm_cmd_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  output logic                        fifo_read_enable,
  input  logic [DATA_W-1:0]           fifo_data,
  input  logic [NUM_CH-1:0]           pwm_period_end,
  output logic [NUM_CH*FIELD_W-1:0]   duty_out,
  output logic [NUM_CH*FIELD_W-1:0]   period_out,
  output logic [NUM_CH-1:0]           ch_enable,
  output logic                        busy,
  output logic [ERR_W-1:0]            err_count
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sched_state_e       state;
  logic [DATA_W-1:0]  cmd_reg;
  logic [PTR_W-1:0]   ch_ptr;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  wr_en;

  // Commit strobe to the selected channel, held off while its shadow is still pending.
  always_comb begin
    wr_en = '0;
    if (state == COMMIT && !pending[ch_ptr]) begin
      wr_en[ch_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      fifo_read_enable <= 1'b0;
      busy             <= 1'b0;
      cmd_reg          <= '0;
      ch_ptr           <= '0;
      err_count        <= '0;
    end else begin
      fifo_read_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state            <= POP;
            fifo_read_enable <= 1'b1;
            busy             <= 1'b1;
          end
        end
        POP: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          cmd_reg <= fifo_data;
          state   <= CHECK;
        end
        CHECK: begin
          if (cmd_valid(cmd_reg)) begin
            state <= COMMIT;
          end else begin
            if (err_count != '1) begin
              err_count <= err_count + ERR_W'(1);
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        COMMIT: begin
          if (!pending[ch_ptr]) begin
            ch_ptr <= (ch_ptr == PTR_W'(NUM_CH - 1)) ? '0 : ch_ptr + PTR_W'(1);
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    pwm_shadow_reg u_shadow (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[n]),
      .wr_data    (cmd_reg),
      .period_end (pwm_period_end[n]),
      .duty       (duty_out[n*FIELD_W +: FIELD_W]),
      .period     (period_out[n*FIELD_W +: FIELD_W]),
      .pending    (pending[n]),
      .enable     (ch_enable[n])
    );
  end

endmodule

// File: tb/tb_pwm_cmd_scheduler.sv
// Directed bench for pwm_cmd_scheduler with a queue-backed FIFO model and hand-computed expectations.
module tb_pwm_cmd_scheduler;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_read_enable;
  logic [15:0] fifo_data;
  logic [3:0]  pwm_period_end;
  logic [31:0] duty_out;
  logic [31:0] period_out;
  logic [3:0]  ch_enable;
  logic        busy;
  logic [7:0]  err_count;

  logic [15:0] fifo_q[$];
  int          pop_count;
  int          tests;
  int          fails;
  logic        prev_re;

  pwm_cmd_scheduler #(.NUM_CH(4), .ERR_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_data        (fifo_data),
    .pwm_period_end   (pwm_period_end),
    .duty_out         (duty_out),
    .period_out       (period_out),
    .ch_enable        (ch_enable),
    .busy             (busy),
    .err_count        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (fifo_q.size() == 0);

  // FIFO model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_read_enable) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      pop_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pop-strobe protocol monitor.
  always @(negedge clk) begin
    if (fifo_read_enable) begin
      check("re_while_empty", 32'(fifo_empty), 32'd0);
      check("re_back_to_back", 32'(prev_re), 32'd0);
    end
    prev_re = fifo_read_enable;
  end

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !busy && !fifo_read_enable) done = 1'b1;
    end
    check(tag, 32'(!done), 32'd0);
  endtask

  task automatic pulse(input logic [3:0] mask);
    pwm_period_end = mask;
    @(negedge clk);
    pwm_period_end = 4'b0000;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic [31:0] p,
                            input logic [3:0] en);
    check({tag, "_duty"}, duty_out, d);
    check({tag, "_period"}, period_out, p);
    check({tag, "_en"}, 32'(ch_enable), 32'(en));
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    pop_count      = 0;
    prev_re        = 1'b0;
    fifo_data      = 16'h0000;
    pwm_period_end = 4'b0000;
    rst            = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset", 32'h0, 32'h0, 4'b0000);
    check("reset_err", 32'(err_count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_re", 32'(fifo_read_enable), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // First command lands on ch0, visible only after its period end.
    push(16'h0A1E);
    wait_idle("wait_cmd0", 50);
    check("pop_once", 32'(pop_count), 32'd1);
    expect_out("cmd0_pending", 32'h0, 32'h0, 4'b0000);
    pulse(4'b0001);
    expect_out("cmd0_applied", 32'h0000000A, 32'h0000001E, 4'b0001);

    // duty > period is rejected, outputs untouched.
    push(16'h140A);
    push(16'h1E14);
    wait_idle("wait_reject", 50);
    check("reject_err", 32'(err_count), 32'd2);
    check("reject_pops", 32'(pop_count), 32'd3);
    expect_out("reject_out", 32'h0000000A, 32'h0000001E, 4'b0001);

    // Round-robin from ch1; each channel applies only on its own pulse.
    push(16'h0510);
    push(16'h0610);
    push(16'h0710);
    push(16'h0810);
    wait_idle("wait_rr", 100);
    expect_out("rr_pending", 32'h0000000A, 32'h0000001E, 4'b0001);
    pulse(4'b0100);
    expect_out("rr_ch2", 32'h0006000A, 32'h0010001E, 4'b0101);
    pulse(4'b0010);
    expect_out("rr_ch1", 32'h0006050A, 32'h0010101E, 4'b0111);
    pulse(4'b1001);
    expect_out("rr_ch3_ch0", 32'h07060508, 32'h10101010, 4'b1111);

    // Fill all shadows, then a fifth command to ch1 must stall in COMMIT.
    push(16'h0410);
    push(16'h0320);
    push(16'h0330);
    push(16'h0340);
    push(16'h0210);
    push(16'h0120);
    repeat (40) @(negedge clk);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_pops", 32'(pop_count), 32'd12);
    check("stall_fifo_kept", 32'(fifo_q.size()), 32'd1);
    expect_out("stall_out", 32'h07060508, 32'h10101010, 4'b1111);
    pulse(4'b0010);
    expect_out("stall_apply_ch1", 32'h07060408, 32'h10101010, 4'b1111);
    check("stall_still_commit", 32'(busy), 32'd1);
    @(negedge clk);
    check("stall_released", 32'(busy), 32'd0);
    pulse(4'b1111);
    wait_idle("wait_after_stall", 100);
    check("after_stall_pops", 32'(pop_count), 32'd13);
    expect_out("after_stall", 32'h03030203, 32'h30201040, 4'b1111);
    pulse(4'b0100);
    expect_out("ch2_second", 32'h03010203, 32'h30201040, 4'b1111);

    // Boundary: period 0 rejected, duty == period accepted (lands on ch3).
    push(16'h0000);
    push(16'h0808);
    wait_idle("wait_bound", 50);
    check("bound_err", 32'(err_count), 32'd3);
    pulse(4'b1000);
    expect_out("full_duty", 32'h08010203, 32'h08201040, 4'b1111);

    // Saturate the reject counter.
    for (int i = 0; i < 252; i++) push(16'h0000);
    wait_idle("wait_sat", 2000);
    check("err_at_max", 32'(err_count), 32'd255);
    push(16'h3002);
    wait_idle("wait_sat2", 50);
    check("err_saturated", 32'(err_count), 32'd255);
    push(16'h0102);
    wait_idle("wait_ptr0", 50);
    pulse(4'b0001);
    expect_out("ptr_after_rejects", 32'h08010201, 32'h08201002, 4'b1111);

    // Reset while the popped word sits in CAPTURE.
    push(16'h0950);
    @(negedge clk);
    check("rst_pop_strobe", 32'(fifo_read_enable), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    expect_out("mid_reset", 32'h0, 32'h0, 4'b0000);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_err", 32'(err_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    push(16'h0A40);
    wait_idle("wait_resume", 50);
    pulse(4'b0001);
    expect_out("resume_ch0", 32'h0000000A, 32'h00000040, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
